// File: rtl/bytelane_ram_ctrl.sv
// rtl/bytelane_ram_ctrl.sv - byte-lane writable RAM with pipelined reads and a full-memory clear engine
module bytelane_ram_ctrl #(
   parameter int         AW       = 12,
   parameter int         NB       = 4,
   parameter int         RD_LAT   = 1,
   parameter int         RDW_MODE = 0,
   parameter logic [7:0] CLR_VAL  = 8'h00
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cs,
   input  logic [NB-1:0]   we,
   input  logic [AW-1:0]   addr,
   input  logic [8*NB-1:0] din,
   input  logic            clr_req,
   output logic [8*NB-1:0] dout,
   output logic            dout_vld,
   output logic            busy
);

   localparam int DW = 8*NB;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t          state, state_nxt;
   logic [AW-1:0]   clr_addr, clr_addr_nxt;
   logic [DW-1:0]   mem [0:(1<<AW)-1];
   logic            acc;
   logic [DW-1:0]   old_word, new_word, rd_word;
   logic            s1_vld;
   logic [DW-1:0]   s1_data;

   assign busy     = (state == CLEAR);
   assign acc      = cs && !busy;
   assign old_word = mem[addr];

   always_comb begin
      new_word = old_word;
      for (int i = 0; i < NB; i++) begin
         if (we[i]) new_word[8*i +: 8] = din[8*i +: 8];
      end
   end

   assign rd_word = (RDW_MODE != 0) ? new_word : old_word;

   always_comb begin
      state_nxt    = state;
      clr_addr_nxt = clr_addr;
      case (state)
         IDLE: begin
            if (clr_req) state_nxt = CLEAR;
         end
         CLEAR: begin
            // counter wraps naturally to 0 on the last word
            clr_addr_nxt = clr_addr + 1'b1;
            if (clr_addr == {AW{1'b1}}) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         clr_addr <= '0;
      end else begin
         state    <= state_nxt;
         clr_addr <= clr_addr_nxt;
      end
   end

   // reset blocks all array writes so an aborted clear stops cleanly
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (busy)
            mem[clr_addr] <= {NB{CLR_VAL}};
         else if (cs)
            mem[addr] <= new_word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld  <= 1'b0;
         s1_data <= '0;
      end else begin
         s1_vld  <= acc;
         s1_data <= acc ? rd_word : '0;
      end
   end

   generate
      if (RD_LAT == 2) begin : g_lat2
         logic          s2_vld;
         logic [DW-1:0] s2_data;
         always_ff @(posedge clk) begin
            if (rst) begin
               s2_vld  <= 1'b0;
               s2_data <= '0;
            end else begin
               s2_vld  <= s1_vld;
               s2_data <= s1_data;
            end
         end
         assign dout     = s2_data;
         assign dout_vld = s2_vld;
      end else begin : g_lat1
         assign dout     = s1_data;
         assign dout_vld = s1_vld;
      end
   endgenerate

endmodule

// File: tb/tb_bytelane_ram_ctrl.sv
// tb/tb_bytelane_ram_ctrl.sv - four latency/RDW variants driven in lockstep against a word-level model
module tb_bytelane_ram_ctrl;

   localparam logic [31:0] CVW = 32'h5A5A5A5A;

   logic        clk;
   logic        rst, cs, clr_req;
   logic [3:0]  we, addr;
   logic [31:0] din;
   logic [31:0] dout_w [4];
   logic        vld_w  [4];
   logic        busy_w [4];

   int checks = 0;
   int errors = 0;
   int k = 0;

   logic [31:0] mm [16];
   int          clr_left = 0;
   int          clr_ptr  = 0;
   bit          rv  [4096];
   bit          rh  [4096];
   logic [31:0] rd0 [4096];
   logic [31:0] rd1 [4096];

   bytelane_ram_ctrl #(.AW(4), .NB(4), .RD_LAT(1), .RDW_MODE(0), .CLR_VAL(8'h5A)) u0 (
      .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr), .din(din), .clr_req(clr_req),
      .dout(dout_w[0]), .dout_vld(vld_w[0]), .busy(busy_w[0]));
   bytelane_ram_ctrl #(.AW(4), .NB(4), .RD_LAT(2), .RDW_MODE(1), .CLR_VAL(8'h5A)) u1 (
      .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr), .din(din), .clr_req(clr_req),
      .dout(dout_w[1]), .dout_vld(vld_w[1]), .busy(busy_w[1]));
   bytelane_ram_ctrl #(.AW(4), .NB(4), .RD_LAT(1), .RDW_MODE(1), .CLR_VAL(8'h5A)) u2 (
      .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr), .din(din), .clr_req(clr_req),
      .dout(dout_w[2]), .dout_vld(vld_w[2]), .busy(busy_w[2]));
   bytelane_ram_ctrl #(.AW(4), .NB(4), .RD_LAT(2), .RDW_MODE(0), .CLR_VAL(8'h5A)) u3 (
      .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr), .din(din), .clr_req(clr_req),
      .dout(dout_w[3]), .dout_vld(vld_w[3]), .busy(busy_w[3]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // advance one clock: update the model for this edge, then compare every variant
   task automatic tick();
      logic [31:0] old, mask, nw, ed;
      bit          ev;
      int          j;
      if (k >= 4095) begin
         $display("FAIL edge_budget: observed %0d expected below 4095", k);
         $fatal(1, "edge budget exhausted");
      end
      rh[k] = rst; rv[k] = 1'b0; rd0[k] = '0; rd1[k] = '0;
      if (rst) begin
         clr_left = 0;
         clr_ptr  = 0;
      end else if (clr_left > 0) begin
         mm[clr_ptr] = CVW;
         clr_ptr++;
         clr_left--;
      end else begin
         if (cs) begin
            old  = mm[addr];
            mask = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
            nw   = (old & ~mask) | (din & mask);
            rv[k] = 1'b1; rd0[k] = old; rd1[k] = nw;
            mm[addr] = nw;
         end
         if (clr_req) begin
            clr_left = 16;
            clr_ptr  = 0;
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (i == 1 || i == 3) begin
            j  = k - 1;
            ev = (rh[k] || k == 0) ? 1'b0 : rv[j];
         end else begin
            j  = k;
            ev = rv[k];
         end
         ed = !ev ? 32'h0 : ((i == 1 || i == 2) ? rd1[j] : rd0[j]);
         chk($sformatf("busy_u%0d@%0d", i, k), 32'(busy_w[i]), 32'(clr_left > 0));
         chk($sformatf("vld_u%0d@%0d", i, k), 32'(vld_w[i]), 32'(ev));
         chk($sformatf("dout_u%0d@%0d", i, k), dout_w[i], ed);
      end
      k++;
   endtask

   initial begin
      int          nb;
      logic [5:0]  h1, h2;
      logic [31:0] pat;

      rst = 1'b1; cs = 1'b0; we = '0; addr = '0; din = '0; clr_req = 1'b0;
      repeat (3) tick();
      chk("rst_busy", 32'(busy_w[0]), 32'h0);
      chk("rst_vld", 32'(vld_w[1]), 32'h0);
      chk("rst_dout", dout_w[1], 32'h0);
      rst = 1'b0;
      tick();

      // full clear with a dropped write while busy
      clr_req = 1'b1; tick(); clr_req = 1'b0;
      nb = 0;
      for (int n = 0; n < 40 && busy_w[0]; n++) begin
         if (n == 3) begin cs = 1'b1; we = 4'hF; addr = 4'd2; din = 32'hDEADBEEF; end
         else cs = 1'b0;
         nb++;
         tick();
      end
      cs = 1'b0;
      chk("clr_busy_cycles", 32'(nb), 32'd16);
      for (int a = 0; a < 16; a++) begin
         cs = 1'b1; we = 4'h0; addr = 4'(a);
         tick();
         chk($sformatf("clr_rd%0d", a), dout_w[0], CVW);
      end

      // byte-lane merge
      addr = 4'd3; we = 4'hF; din = 32'h11223344; tick();
      we = 4'b0101; din = 32'hAABBCCDD; tick();
      we = 4'h0; tick();
      chk("lane_lat1", dout_w[0], 32'h11BB33DD);
      cs = 1'b0; tick();
      chk("lane_lat2", dout_w[1], 32'h11BB33DD);

      // four back-to-back reads
      for (int t = 0; t < 6; t++) begin
         cs = (t < 4); we = 4'h0; addr = 4'(t);
         tick();
         h1[t] = vld_w[0];
         h2[t] = vld_w[1];
      end
      chk("lat1_pulses", 32'(h1), 32'(6'b001111));
      chk("lat2_pulses", 32'(h2), 32'(6'b011110));

      // read-during-write
      cs = 1'b1; addr = 4'd9; we = 4'hF; din = 32'h0; tick();
      we = 4'b0011; din = 32'hFFFFFFFF; tick();
      chk("rdw0_lat1", dout_w[0], 32'h00000000);
      chk("rdw1_lat1", dout_w[2], 32'h0000FFFF);
      cs = 1'b0; tick();
      chk("rdw1_lat2", dout_w[1], 32'h0000FFFF);
      chk("rdw0_lat2", dout_w[3], 32'h00000000);

      // aborted clear
      for (int a = 0; a < 16; a++) begin
         cs = 1'b1; we = 4'hF; addr = 4'(a); din = 32'h10000000 + 32'(a) * 32'h01010101;
         tick();
      end
      cs = 1'b0; clr_req = 1'b1; tick(); clr_req = 1'b0;
      repeat (5) tick();
      rst = 1'b1; tick(); rst = 1'b0;
      chk("abort_busy", 32'(busy_w[0]), 32'h0);
      for (int a = 0; a < 16; a++) begin
         cs = 1'b1; we = 4'h0; addr = 4'(a);
         tick();
         pat = (a < 5) ? CVW : 32'h10000000 + 32'(a) * 32'h01010101;
         chk($sformatf("abort_rd%0d", a), dout_w[0], pat);
      end

      // write and clear request together
      cs = 1'b1; we = 4'hF; addr = 4'd7; din = 32'hCAFEF00D; clr_req = 1'b1;
      tick();
      cs = 1'b0; clr_req = 1'b0;
      chk("sim_vld", 32'(vld_w[0]), 32'h1);
      chk("sim_old", dout_w[0], 32'h17070707);
      chk("sim_new", dout_w[2], 32'hCAFEF00D);
      nb = 0;
      for (int n = 0; n < 40 && busy_w[0]; n++) begin
         nb++;
         tick();
      end
      chk("sim_busy_cycles", 32'(nb), 32'd16);
      cs = 1'b1; we = 4'h0; addr = 4'd7; tick();
      chk("sim_cleared", dout_w[0], CVW);

      // randomized traffic
      for (int n = 0; n < 1500; n++) begin
         rst     = ($urandom % 200) == 0;
         cs      = ($urandom % 4) != 0;
         we      = 4'($urandom);
         addr    = 4'($urandom);
         din     = $urandom;
         clr_req = ($urandom % 100) == 0;
         tick();
      end
      rst = 1'b0; cs = 1'b0; clr_req = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bytelane_ram_ctrl.md
BYTELANE_RAM_CTRL -- requirements
Module: bytelane_ram_ctrl

Interface
REQ-001 SHALL have parameter AW, default 12, meaning word-address width; depth is 2**AW words.
REQ-002 SHALL have parameter NB, default 4, meaning byte lanes per word; data width is 8*NB.
REQ-003 SHALL have parameter RD_LAT, default 1, meaning read latency in cycles; only legal values are 1 and 2.
REQ-004 SHALL have parameter RDW_MODE, default 0, meaning read-during-write result: 0 returns old data, 1 returns new data.
REQ-005 SHALL have parameter CLR_VAL, default 8'h00, meaning the byte value written to every lane by the clear engine.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-008 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-009 SHALL have port cs, input, 1, access request for this cycle.
REQ-010 SHALL have port we, input, NB, per-lane write enable; bit i enables byte lane i, din[8i+7:8i].
REQ-011 SHALL have port addr, input, AW, word address.
REQ-012 SHALL have port din, input, 8*NB, write data; lane i is taken from din[8i+7:8i].
REQ-013 SHALL have port clr_req, input, 1, single-cycle pulse that starts a full-memory clear.
REQ-014 SHALL have port dout, output, 8*NB, read data.
REQ-015 SHALL have port dout_vld, output, 1, qualifies dout.
REQ-016 SHALL have port busy, output, 1, high while the clear engine owns the array.

Function
REQ-017 SHALL accept an access when cs=1 and busy=0; cs while busy=1 is dropped with no write and no read response.
REQ-018 SHALL, on an accepted access, write lane i of addr with din lane i for every we[i]=1 and leave lanes with we[i]=0 unchanged.
REQ-019 SHALL treat every accepted access, including writes, as a read of addr.
REQ-020 SHALL return each read exactly RD_LAT cycles after the accept edge with dout_vld=1 for one cycle.
REQ-021 SHALL accept back-to-back accesses at one per cycle; RD_LAT=2 registers dout with no bubbles.
REQ-022 SHALL drive dout=0 whenever dout_vld=0.
REQ-023 SHALL, with RDW_MODE=0, return pre-write bytes on all lanes for a write access.
REQ-024 SHALL, with RDW_MODE=1, return din on written lanes and stored bytes on unwritten lanes for a write access.
REQ-025 SHALL implement clear FSM states IDLE and CLEAR, with reset state IDLE.
REQ-026 SHALL transition IDLE->CLEAR on clr_req=1; busy=1 from the next cycle.
REQ-027 SHALL, in CLEAR, write CLR_VAL to all NB lanes at clear address 0, 1, ..., 2**AW-1, one word per cycle.
REQ-028 SHALL return CLEAR->IDLE after writing the last address, so busy is high for exactly 2**AW cycles.
REQ-029 SHALL ignore clr_req while in CLEAR; the clear is neither restarted nor extended.
REQ-030 SHALL, when cs and clr_req are both high in IDLE, perform the access that cycle and start the clear on the next cycle.
REQ-031 SHALL complete read responses already in the pipeline when the clear starts, returning pre-clear data.
REQ-032 SHALL wrap the clear address counter to 0 at the end of a clear with no extra cycle.

Reset
REQ-033 SHALL, with rst=1, force the FSM to IDLE, busy=0, dout_vld=0, dout=0, flush the read pipeline and zero the clear counter.
REQ-034 SHALL abort an in-progress clear on reset, leaving already-cleared words cleared and the remainder unchanged.
REQ-035 SHALL not initialise array contents on reset.
REQ-036 SHALL give rst priority over cs and clr_req in the same cycle.

Verification
REQ-037 SHALL be verified for lane writes (NB=4): write 0x11223344 with we=4'hF, then write 0xAABBCCDD with we=4'b0101, then read -> dout=0x11BB33DD.
REQ-038 SHALL be verified for latency: RD_LAT=1 and then RD_LAT=2, 4 back-to-back reads -> 4 consecutive dout_vld pulses starting 1 (or 2) cycles later, with dout=0 outside them.
REQ-039 SHALL be verified for RDW: location holds 0x0; write 0xFFFFFFFF with we=4'b0011 -> RDW_MODE=0 returns 0x00000000 and RDW_MODE=1 returns 0x0000FFFF.
REQ-040 SHALL be verified for clear: AW=4, pulse clr_req -> busy high exactly 16 cycles, cs during busy dropped, then every address reads CLR_VAL on all lanes.
REQ-041 SHALL be verified for clear abort: assert rst at clear cycle 5 -> busy=0 the next cycle, addresses 0-4 read CLR_VAL and addresses 5-15 keep their prior data.
REQ-042 SHALL be verified for simultaneous events: cs write and clr_req in the same IDLE cycle -> the write response is returned and the written data is then overwritten by the clear.
